uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DIV_W, 16, width of the baud divisor.
REQ-002 Parameter DEPTH, 8, receive FIFO depth in bytes; power of 2, at least 2.
REQ-003 Port clk, input, 1, system clock; all logic on rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port rx, input, 1, serial line, idle high, asynchronous to clk.
REQ-006 Port baud_div, input, DIV_W, clk cycles per bit; values 0 and 1 treated as 2.
REQ-007 Port data_bits, input, 2, data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-008 Port parity_en, input, 1, parity bit present after the data bits.
REQ-009 Port parity_odd, input, 1, 1=odd parity, 0=even parity.
REQ-010 Port stop2, input, 1, two stop bits checked when set.
REQ-011 Port rd_en, input, 1, pop request; ignored when rd_valid=0.
REQ-012 Port rd_data, output, 8, head byte (show-ahead); unused upper bits zero.
REQ-013 Port rd_valid, output, 1, receive buffer not empty.
REQ-014 Port level, output, $clog2(DEPTH)+1, bytes held in the buffer.
REQ-015 Port parity_err, frame_err, overrun, output, 1 each, single-cycle error pulses.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser; all sampling uses the synchronised value (2-cycle input latency).
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; encoding free; unused encodings return to IDLE.
REQ-018 IDLE: synced rx=0 -> START, bit counter cleared; baud_div, data_bits, parity_en, parity_odd and stop2 latched for the whole frame.
REQ-019 START: at count = div>>1, rx=0 -> DATA with count and bit index cleared; rx=1 -> IDLE with no error.
REQ-020 DATA: sample at count = div-1, LSB first, count cleared; after N bits -> PARITY if parity enabled, else STOP.
REQ-021 PARITY: sample at div-1; error if XOR(data, parity bit) is not equal to parity_odd.
REQ-022 STOP: sample at div-1; any stop sample of 0 flags a framing error; with stop2, two stop bits are sampled.
REQ-023 Frame end: if no error, push the byte; otherwise discard it and pulse the matching error flag(s) one cycle after the final stop sample, then return to IDLE.
REQ-024 A pushed byte SHALL appear on rd_valid/rd_data on the cycle after the final stop sample.
REQ-025 Push when full with no pop: byte dropped, contents unchanged, overrun pulses once.
REQ-026 Push and pop in the same cycle: both take effect, level unchanged, no overrun.
REQ-027 Pop when empty: no effect; level never underflows.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 rst_n low, including mid-frame: FSM IDLE, counters zero, synchroniser flops 1, buffer empty.
REQ-030 Reset outputs: rd_data=0, rd_valid=0, level=0, all error pulses 0.

Configuration
REQ-031 With UART_RX_FIFO_EN defined, the buffer SHALL be a DEPTH-entry FIFO as described above.
REQ-032 Without UART_RX_FIFO_EN, the buffer SHALL be a single holding register (level 0/1): DEPTH ignored, same overrun/same-cycle rules, same port list.

Verification
REQ-033 baud_div=16, 8N1, byte 0xA5 -> rd_valid=1, rd_data=0xA5, level=1, no error pulse.
REQ-034 7E1, byte 0x35 with parity bit 1 -> parity_err pulses once, rd_valid stays 0.
REQ-035 8N1, stop bit 0 -> frame_err pulses once, no push; next valid frame 0x3C is received correctly.
REQ-036 rx low for 4 cycles with baud_div=16 -> return to IDLE, no push, no error.
REQ-037 FIFO_EN, DEPTH=8: 9 frames 0x00..0x08 -> overrun pulses once, level=8, pops return 0x00..0x07; without the macro, second frame -> overrun, rd_data=0x00.
REQ-038 5O2, byte 0x15, second stop bit 0 -> frame_err pulses; reset asserted mid-frame -> outputs at reset values.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a receive buffer.
//
// Frames are start bit, 5..8 data bits (LSB first), optional parity bit,
// and one or two stop bits. The line is sampled near the middle of each bit
// using baud_div clk cycles per bit. Good bytes go into the receive buffer.
// Bad frames are discarded and raise a one-cycle error pulse.
//
// Build option UART_RX_FIFO_EN:
//   defined   - the receive buffer is a DEPTH-entry FIFO.
//   undefined - the receive buffer is a single holding register
//               (level 0/1, DEPTH unused).
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   rx              serial line (idle high, asynchronous to clk)
//   baud_div        clk cycles per bit (0 and 1 behave as 2)
//   data_bits       00=5, 01=6, 10=7, 11=8 data bits
//   parity_en       a parity bit follows the data bits
//   parity_odd      1 = odd parity, 0 = even parity
//   stop2           check two stop bits
//   rd_en           pop the head byte (ignored while rd_valid=0)
//   rd_data         head byte, show-ahead, zero-extended; 0 when empty
//   rd_valid        buffer not empty
//   level           number of bytes held
//   parity_err, frame_err, overrun   single-cycle error pulses
module uart_rx_cfg #(
    parameter int DIV_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic [1:0]             data_bits,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   stop2,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       nbits_q, nbits_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             stop2_q, stop2_d;
    logic             stop_idx_q, stop_idx_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       data_q, data_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             push;
    logic             rx_s;
    logic             bit_end;
    logic             ferr_now;

    assign rx_s     = sync2_q;
    assign bit_end  = (cnt_q == div_q - DIV_W'(1));
    // Framing status including the stop bit being sampled this cycle.
    assign ferr_now = ferr_q | ~rx_s;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        bit_idx_d    = bit_idx_q;
        nbits_d      = nbits_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        stop2_d      = stop2_q;
        stop_idx_d   = stop_idx_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    // Frame settings are frozen here so that mid-frame
                    // changes on the config inputs cannot corrupt it.
                    state_d    = START;
                    cnt_d      = '0;
                    div_d      = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
                    nbits_d    = data_bits;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                    stop2_d    = stop2;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    data_d     = '0;
                end
            end
            START: begin
                if (cnt_q == (div_q >> 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is no longer low at mid-bit is a
                    // glitch: drop it silently.
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d             = '0;
                    data_d[bit_idx_q] = rx_s;
                    bit_idx_d         = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd4 + {1'b0, nbits_q}) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (((^data_q) ^ rx_s) != par_odd_q) begin
                        perr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        ferr_d     = ferr_now;
                    end else begin
                        state_d = IDLE;
                        if (perr_q || ferr_now) begin
                            parity_err_d = perr_q;
                            frame_err_d  = ferr_now;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_idx_q    <= '0;
            nbits_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_idx_q    <= bit_idx_d;
            nbits_q      <= nbits_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop2_q      <= stop2_d;
            stop_idx_q   <= stop_idx_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, pop, do_push;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign pop       = rd_en & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push   = push & (~full | pop);
    assign overrun_d = push & full & ~pop;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level    = count_q;
`else
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       pop, do_push;

    assign pop       = rd_en & full_q;
    assign do_push   = push & (~full_q | pop);
    assign overrun_d = push & full_q & ~pop;

    always_comb begin
        hold_d = do_push ? data_q : hold_q;
        full_d = do_push | (full_q & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign rd_valid = full_q;
    assign rd_data  = full_q ? hold_q : 8'h00;
    assign level    = {{($clog2(DEPTH)){1'b0}}, full_q};
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int DIV_W = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd16;
    logic [1:0]       data_bits = 2'b11;
    logic             parity_en = 1'b0;
    logic             parity_odd = 1'b0;
    logic             stop2 = 1'b0;
    logic             rd_en = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [LW-1:0]    level;
    logic             parity_err, frame_err, overrun;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int n_perr = 0, n_ferr = 0, n_ovr = 0;
    int evt_cyc = -1;
    logic [LW-1:0] lvl_prev = '0;

    // Reference model: buffer contents as a queue.
    logic [7:0] mq[$];
    int e_perr, e_ferr, e_ovr, o_perr, o_ferr, o_ovr, push_c;

    uart_rx_cfg #(.DIV_W(DIV_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and the cycle of the most recent visible event.
    always @(negedge clk) begin
        if (parity_err === 1'b1) begin n_perr++; evt_cyc = cyc; end
        if (frame_err === 1'b1) begin n_ferr++; evt_cyc = cyc; end
        if (overrun === 1'b1) begin n_ovr++; evt_cyc = cyc; end
        if (level !== lvl_prev) evt_cyc = cyc;
        lvl_prev = level;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one frame; the model decides the outcome from the frame rules.
    // The final stop sample lands half a bit into each bit period after the
    // 2-cycle synchroniser and one detect cycle, so the buffer / error
    // update edge is start + 4 + div/2 + (bits after start) * div.
    task automatic send_frame(input int div, input logic [7:0] dat, input int nb,
                              input bit pen, input bit podd, input bit s2,
                              input bit pflip, input bit sb0, input bit sb1,
                              input bit pop_now);
        bit line[$];
        logic [7:0] m;
        bit pb;
        int b_p, b_f, b_o, nsl;
        m  = dat & ((8'd1 << nb) - 8'd1);
        pb = (^m) ^ podd ^ pflip;
        line.push_back(1'b0);
        for (int i = 0; i < nb; i++) line.push_back(m[i]);
        if (pen) line.push_back(pb);
        line.push_back(sb0);
        if (s2) line.push_back(sb1);
        nsl = line.size() - 1;
        e_perr = (pen && (((^m) ^ pb) != podd)) ? 1 : 0;
        e_ferr = (!sb0 || (s2 && !sb1)) ? 1 : 0;
        e_ovr  = 0;
        if (pop_now && mq.size() > 0) mq.delete(0);
        if (e_perr == 0 && e_ferr == 0) begin
            if (mq.size() < CAP) mq.push_back(m);
            else e_ovr = 1;
        end
        baud_div   = DIV_W'(div);
        data_bits  = 2'(nb - 5);
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
        b_p = n_perr; b_f = n_ferr; b_o = n_ovr;
        @(posedge clk); #1;
        push_c = cyc + 4 + div / 2 + nsl * div;
        for (int k = 0; k < (line.size() + 3) * div; k++) begin
            rx    = (k / div < line.size()) ? line[k / div] : 1'b1;
            rd_en = pop_now && (cyc == push_c - 1);
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        rx    = 1'b1;
        o_perr = n_perr - b_p;
        o_ferr = n_ferr - b_f;
        o_ovr  = n_ovr - b_o;
        $display("frame div=%0d nb=%0d pen=%0b odd=%0b s2=%0b byte=%02h stops=%0b%0b pop=%0b -> perr=%0d ferr=%0d ovr=%0d level=%0d",
                 div, nb, pen, podd, s2, m, sb0, sb1, pop_now, o_perr, o_ferr, o_ovr, level);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rd_data); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++; if (n_perr + n_ferr + n_ovr != 0) begin bad++; $display("FAIL reset_pulses got=%0d want=0", n_perr + n_ferr + n_ovr); end
        $display("reset checked");
    endtask

    task automatic test_basic();
        send_frame(16, 8'hA5, 8, 0, 0, 0, 0, 1, 1, 0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", rd_valid); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", rd_data); end
        total++; if (level !== LW'(1)) begin bad++; $display("FAIL basic_level got=%0d want=1", level); end
        total++; if (o_perr + o_ferr + o_ovr != 0) begin bad++; $display("FAIL basic_err got=%0d want=0", o_perr + o_ferr + o_ovr); end
        total++; if (evt_cyc != push_c) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", evt_cyc, push_c); end
    endtask

    task automatic test_drain();
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== mq[0]) begin
                bad++; $display("FAIL drain_head got=%b/%h want=1/%h", rd_valid, rd_data, mq[0]);
            end
            do_pop();
            mq.delete(0);
        end
        total++; if (rd_valid !== 1'b0 || level !== '0) begin
            bad++; $display("FAIL drain_empty got=%b/%0d want=0/0", rd_valid, level);
        end
    endtask

    task automatic test_pop_empty();
        do_pop();
        do_pop();
        total++; if (level !== '0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL pop_empty got=%0d/%b want=0/0", level, rd_valid);
        end
    endtask

    task automatic test_parity();
        // 7E1, 0x35 has four ones, so a parity bit of 1 is wrong.
        send_frame(16, 8'h35, 7, 1, 0, 0, 1, 1, 1, 0);
        total++; if (o_perr != 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", o_perr); end
        total++; if (o_ferr != 0) begin bad++; $display("FAIL parity_noframe got=%0d want=0", o_ferr); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL parity_valid got=%b want=0", rd_valid); end
        total++; if (evt_cyc != push_c) begin bad++; $display("FAIL parity_latency got=%0d want=%0d", evt_cyc, push_c); end
    endtask

    task automatic test_frame();
        send_frame(16, 8'h5A, 8, 0, 0, 0, 0, 0, 1, 0);
        total++; if (o_ferr != 1) begin bad++; $display("FAIL frame_pulse got=%0d want=1", o_ferr); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL frame_nopush got=%b want=0", rd_valid); end
        send_frame(16, 8'h3C, 8, 0, 0, 0, 0, 1, 1, 0);
        total++; if (rd_data !== 8'h3C || level !== LW'(1)) begin
            bad++; $display("FAIL frame_next got=%h/%0d want=3c/1", rd_data, level);
        end
    endtask

    task automatic test_glitch();
        int b_p, b_f, b_o, ev;
        b_p = n_perr; b_f = n_ferr; b_o = n_ovr; ev = evt_cyc;
        baud_div = 16'd16;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        $display("glitch done level=%0d", level);
        total++; if (n_perr + n_ferr + n_ovr != b_p + b_f + b_o) begin bad++; $display("FAIL glitch_err got=%0d want=0", n_perr + n_ferr + n_ovr - b_p - b_f - b_o); end
        total++; if (evt_cyc != ev || level !== LW'(mq.size())) begin bad++; $display("FAIL glitch_level got=%0d want=%0d", level, mq.size()); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL glitch_data got=%h want=3c", rd_data); end
    endtask

    task automatic test_overrun();
        int ovr_sum = 0;
        for (int i = 0; i <= CAP; i++) begin
            send_frame(12, 8'(i), 8, 0, 0, 0, 0, 1, 1, 0);
            ovr_sum += o_ovr;
        end
        total++; if (ovr_sum != 1 || o_ovr != 1) begin bad++; $display("FAIL overrun_count got=%0d want=1", ovr_sum); end
        total++; if (evt_cyc != push_c) begin bad++; $display("FAIL overrun_latency got=%0d want=%0d", evt_cyc, push_c); end
        total++; if (level !== LW'(CAP)) begin bad++; $display("FAIL overrun_level got=%0d want=%0d", level, CAP); end
        for (int i = 0; i < CAP; i++) begin
            total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL overrun_pop got=%h want=%h", rd_data, 8'(i)); end
            do_pop();
            mq.delete(0);
        end
        total++; if (level !== '0) begin bad++; $display("FAIL overrun_empty got=%0d want=0", level); end
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < CAP; i++) send_frame(10, 8'h40 + 8'(i), 8, 0, 0, 0, 0, 1, 1, 0);
        send_frame(10, 8'h7E, 8, 0, 0, 0, 0, 1, 1, 1);
        total++; if (o_ovr != 0) begin bad++; $display("FAIL same_cycle_ovr got=%0d want=0", o_ovr); end
        total++; if (level !== LW'(CAP)) begin bad++; $display("FAIL same_cycle_level got=%0d want=%0d", level, CAP); end
        test_drain();
    endtask

    task automatic test_stop2();
        send_frame(16, 8'h15, 5, 1, 1, 1, 0, 1, 0, 0);
        total++; if (o_ferr != 1 || o_perr != 0) begin bad++; $display("FAIL stop2_pulse got=%0d/%0d want=1/0", o_ferr, o_perr); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL stop2_nopush got=%b want=0", rd_valid); end
    endtask

    task automatic test_reset_mid();
        send_frame(16, 8'hC1, 8, 0, 0, 0, 0, 1, 1, 0);
        baud_div = 16'd16;
        rx = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== '0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%0d want=0/00/0", rd_valid, rd_data, level);
        end
        total++; if (parity_err !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL mid_reset_pulses got=%b%b%b want=000", parity_err, frame_err, overrun);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        send_frame(16, 8'hC3, 8, 0, 0, 0, 0, 1, 1, 0);
        total++; if (rd_data !== 8'hC3 || level !== LW'(1) || o_perr + o_ferr != 0) begin
            bad++; $display("FAIL mid_reset_recover got=%h/%0d want=c3/1", rd_data, level);
        end
        test_drain();
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            send_frame($urandom_range(6, 20), 8'($urandom_range(0, 255)), $urandom_range(5, 8),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
            total++; if (o_perr != e_perr || o_ferr != e_ferr || o_ovr != e_ovr) begin
                bad++; $display("FAIL rand_pulses t=%0d got=%0d%0d%0d want=%0d%0d%0d", t, o_perr, o_ferr, o_ovr, e_perr, e_ferr, e_ovr);
            end
            total++; if (level !== LW'(mq.size())) begin
                bad++; $display("FAIL rand_level t=%0d got=%0d want=%0d", t, level, mq.size());
            end
            total++; if (rd_data !== ((mq.size() > 0) ? mq[0] : 8'h00)) begin
                bad++; $display("FAIL rand_head t=%0d got=%h want=%h", t, rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
            end
            if ($urandom_range(0, 1) == 1 && mq.size() > 0) begin
                do_pop();
                mq.delete(0);
                total++; if (level !== LW'(mq.size())) begin
                    bad++; $display("FAIL rand_pop t=%0d got=%0d want=%0d", t, level, mq.size());
                end
            end
        end
        test_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_pop_empty();
        test_parity();
        test_frame();
        test_glitch();
        test_drain();
        test_overrun();
        test_same_cycle();
        test_stop2();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
